// File: rtl/ntt_twiddle_addr_gen.sv
// Twiddle read-address sequencer for one NTT/INTT unit: walks passes x beats and emits one root-RAM row per butterfly level.
// Optional sticky error flag (illegal start / over-long stall) enabled by defining TWIDDLE_ERR_FLAG_EN.
module ntt_twiddle_addr_gen #(
  parameter int N              = 4096,
  parameter int E              = 8,
  parameter int ROOT_POWER_NUM = 4,
  parameter int GAP_CYCLES     = 4,
  localparam int LOGE   = $clog2(E),
  localparam int LOG_N  = $clog2(N),
  localparam int NB     = N / E,
  localparam int LOG_NB = $clog2(NB),
  localparam int P      = LOG_N / LOGE,
  localparam int ADDR_W = $clog2(N / (E / 2)),
  localparam int RSEL_W = (ROOT_POWER_NUM > 1) ? $clog2(ROOT_POWER_NUM) : 1,
  localparam int PASS_W = (P > 1) ? $clog2(P) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         intt_mode_i,
  input  logic [RSEL_W-1:0]            root_sel_in_i,
  input  logic                         hold_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         addr_valid_o,
  output logic [LOGE-1:0][ADDR_W-1:0]  raddr_o,
  output logic [RSEL_W-1:0]            root_select_o,
  output logic [PASS_W-1:0]            pass_idx_o,
  output logic [LOG_NB-1:0]            beat_idx_o,
  output logic                         last_beat_o
`ifdef TWIDDLE_ERR_FLAG_EN
  ,output logic                        err_o
`endif
);

  if (LOG_N % LOGE != 0) begin : g_bad_cfg
    $error("ntt_twiddle_addr_gen: log2(N) must be a multiple of log2(E)");
  end

  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_INIT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [LOG_NB-1:0] BEAT_LAST = LOG_NB'(NB - 1);
  localparam logic [LOG_NB-1:0] BEAT_ONE  = LOG_NB'(1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(P - 1);
  localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_INIT);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_e;

  state_e                      state_q;
  logic [PASS_W-1:0]           pass_q;
  logic [LOG_NB-1:0]           beat_q;
  logic                        mode_q;
  logic [GAP_W-1:0]            gap_q;
  logic                        busy_q, done_q, valid_q, last_q;
  logic [LOGE-1:0][ADDR_W-1:0] raddr_q;
  logic [RSEL_W-1:0]           rsel_q;
  logic [PASS_W-1:0]           pass_idx_q;
  logic [LOG_NB-1:0]           beat_idx_q;

  logic                        idle_c, emit_c, end_beat_c, end_pass_c, cur_mode_c;
  logic [PASS_W-1:0]           cur_pass_c;
  logic [LOG_NB-1:0]           cur_beat_c;
  logic [LOGE-1:0][ADDR_W-1:0] raddr_c;
  int                          stage_c, lvl_c;

  // pass_q/beat_q name the next beat to emit; an accepted start emits beat 0 on the same edge.
  always_comb begin
    idle_c     = (state_q == IDLE);
    cur_pass_c = idle_c ? '0 : pass_q;
    cur_beat_c = idle_c ? '0 : beat_q;
    cur_mode_c = idle_c ? intt_mode_i : mode_q;
    emit_c     = !hold_i && ((idle_c && start_i) || (state_q == RUN));
    end_beat_c = (cur_beat_c == BEAT_LAST);
    end_pass_c = (cur_pass_c == PASS_LAST);
    raddr_c    = '0;
    stage_c    = 0;
    lvl_c      = 0;
    for (int l = 0; l < LOGE; l++) begin
      stage_c = int'(cur_pass_c) * LOGE + l;
      if (cur_mode_c) stage_c = LOG_N - 1 - stage_c;
      lvl_c      = (stage_c < LOG_NB) ? stage_c : LOG_NB;
      raddr_c[l] = ADDR_W'((1 << lvl_c) - 1) + ADDR_W'(cur_beat_c >> (LOG_NB - lvl_c));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pass_q     <= '0;
      beat_q     <= '0;
      mode_q     <= 1'b0;
      gap_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      raddr_q    <= '0;
      rsel_q     <= '0;
      pass_idx_q <= '0;
      beat_idx_q <= '0;
    end else begin
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          mode_q  <= intt_mode_i;
          rsel_q  <= root_sel_in_i;
          busy_q  <= 1'b1;
          pass_q  <= '0;
          beat_q  <= '0;
          state_q <= RUN;
        end
        GAP: begin
          if (gap_q == '0) state_q <= RUN;
          else             gap_q   <= gap_q - GAP_ONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: ;
      endcase
      // Later assignments here override the state-case defaults above.
      if (emit_c) begin
        valid_q    <= 1'b1;
        raddr_q    <= raddr_c;
        pass_idx_q <= cur_pass_c;
        beat_idx_q <= cur_beat_c;
        last_q     <= end_beat_c && end_pass_c;
        if (!end_beat_c) begin
          beat_q <= cur_beat_c + BEAT_ONE;
        end else if (end_pass_c) begin
          state_q <= DONE;
        end else begin
          pass_q <= cur_pass_c + PASS_ONE;
          beat_q <= '0;
          if (GAP_CYCLES > 0) begin
            state_q <= GAP;
            gap_q   <= GAP_LOAD;
          end
        end
      end
    end
  end

`ifdef TWIDDLE_ERR_FLAG_EN
  localparam logic [LOG_NB:0] HOLD_LIMIT = (LOG_NB + 1)'(NB);
  localparam logic [LOG_NB:0] HOLD_ONE   = (LOG_NB + 1)'(1);

  logic [LOG_NB:0] hold_run_q;
  logic            err_q;

  // hold_run_q counts earlier consecutive stalled RUN cycles; reaching NB means this is stall NB+1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_run_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == RUN && hold_i) begin
        if (hold_run_q != HOLD_LIMIT) hold_run_q <= hold_run_q + HOLD_ONE;
        else                          err_q      <= 1'b1;
      end else begin
        hold_run_q <= '0;
      end
      if (start_i && state_q != IDLE) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign addr_valid_o  = valid_q;
  assign raddr_o       = raddr_q;
  assign root_select_o = rsel_q;
  assign pass_idx_o    = pass_idx_q;
  assign beat_idx_o    = beat_idx_q;
  assign last_beat_o   = last_q;

endmodule

// File: tb/tb_ntt_twiddle_addr_gen.sv
// Self-checking bench for ntt_twiddle_addr_gen at N=64, E=8, GAP=4: directed timing runs plus an address vector table.
module tb_ntt_twiddle_addr_gen;
  localparam int MAXC = 32;

  logic            clk = 1'b0;
  logic            rstN;
  logic            start, inttMode, hold;
  logic [1:0]      rootSel;
  logic            busy, done, addrValid, lastBeat;
  logic [2:0][3:0] raddr;
  logic [1:0]      rootSelect;
  logic [0:0]      passIdx;
  logic [2:0]      beatIdx;
`ifdef TWIDDLE_ERR_FLAG_EN
  logic            err;
`endif

  ntt_twiddle_addr_gen #(.N(64), .E(8), .ROOT_POWER_NUM(4), .GAP_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rstN), .start_i(start), .intt_mode_i(inttMode),
    .root_sel_in_i(rootSel), .hold_i(hold), .busy_o(busy), .done_o(done),
    .addr_valid_o(addrValid), .raddr_o(raddr), .root_select_o(rootSelect),
    .pass_idx_o(passIdx), .beat_idx_o(beatIdx), .last_beat_o(lastBeat)
`ifdef TWIDDLE_ERR_FLAG_EN
    , .err_o(err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic            trValid [MAXC];
  logic            trBusy  [MAXC];
  logic            trDone  [MAXC];
  logic            trLast  [MAXC];
  logic [1:0]      trRsel  [MAXC];
  logic [0:0]      trPass  [MAXC];
  logic [2:0]      trBeat  [MAXC];
  logic [2:0][3:0] trRaddr [MAXC];

  typedef struct {
    logic mode;
    int   pass;
    int   beat;
    int   r0, r1, r2;
  } vecT;
  vecT vecs [11];

  task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Start at cycle 0, then record outputs for cycles 1..cycles-1 while driving hold/extra start.
  task applyStimulus(input logic mode, input logic [1:0] rsel, input int holdFrom, input int holdTo,
                     input int extraStart, input int cycles);
    @(posedge clk); #1;
    start = 1'b1; inttMode = mode; rootSel = rsel; hold = 1'b0;
    @(posedge clk); #1;
    inttMode = ~mode; rootSel = ~rsel;
    trValid[0] = 1'b0;
    for (int k = 1; k < cycles; k++) begin
      hold  = (k >= holdFrom && k <= holdTo);
      start = (k == extraStart);
      @(negedge clk);
      trValid[k] = addrValid; trBusy[k] = busy; trDone[k] = done; trLast[k] = lastBeat;
      trRsel[k]  = rootSelect; trPass[k] = passIdx; trBeat[k] = beatIdx; trRaddr[k] = raddr;
      @(posedge clk); #1;
    end
    start = 1'b0; hold = 1'b0;
  endtask

  function automatic bit nominalValid(input int k, input int hs);
    if (hs == 0) return (k >= 1 && k <= 8) || (k >= 13 && k <= 20);
    return (k >= 1 && k <= 3) || (k >= 7 && k <= 11) || (k >= 16 && k <= 23);
  endfunction

  task checkRun(input string tag, input int hs, input logic [1:0] rsel, input int cycles);
    int n;
    n = 0;
    for (int k = 1; k < cycles; k++) begin
      checkOutput($sformatf("%s valid c%0d", tag, k), trValid[k], nominalValid(k, hs));
      checkOutput($sformatf("%s busy c%0d", tag, k), trBusy[k], (k <= 20 + hs));
      checkOutput($sformatf("%s done c%0d", tag, k), trDone[k], (k == 21 + hs));
      checkOutput($sformatf("%s last c%0d", tag, k), trLast[k], (k == 20 + hs));
      if (trValid[k] === 1'b1) begin
        checkOutput($sformatf("%s pass n%0d", tag, n), trPass[k], n / 8);
        checkOutput($sformatf("%s beat n%0d", tag, n), trBeat[k], n % 8);
        checkOutput($sformatf("%s rsel n%0d", tag, n), trRsel[k], rsel);
        n++;
      end
    end
    checkOutput($sformatf("%s validCount", tag), n, 16);
  endtask

  task checkTable(input logic mode, input int cycles);
    bit found;
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].mode == mode) begin
        found = 0;
        for (int k = 1; k < cycles; k++) begin
          if (!found && trValid[k] === 1'b1 && trPass[k] == vecs[i].pass && trBeat[k] == vecs[i].beat) begin
            found = 1;
            checkOutput($sformatf("vec%0d raddr0", i), trRaddr[k][0], vecs[i].r0);
            checkOutput($sformatf("vec%0d raddr1", i), trRaddr[k][1], vecs[i].r1);
            checkOutput($sformatf("vec%0d raddr2", i), trRaddr[k][2], vecs[i].r2);
          end
        end
        if (!found) checkOutput($sformatf("vec%0d found", i), 0, 1);
      end
    end
  endtask

  task checkAllZero(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " valid"}, addrValid, 0);
    checkOutput({tag, " last"}, lastBeat, 0);
    checkOutput({tag, " raddr"}, raddr, 0);
    checkOutput({tag, " rsel"}, rootSelect, 0);
    checkOutput({tag, " pass"}, passIdx, 0);
    checkOutput({tag, " beat"}, beatIdx, 0);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, 0, 5, 0, 2, 5};
    vecs[1]  = '{1'b0, 1, 5, 12, 12, 12};
    vecs[2]  = '{1'b0, 1, 0, 7, 7, 7};
    vecs[3]  = '{1'b0, 0, 0, 0, 1, 3};
    vecs[4]  = '{1'b0, 0, 7, 0, 2, 6};
    vecs[5]  = '{1'b0, 1, 7, 14, 14, 14};
    vecs[6]  = '{1'b1, 0, 5, 12, 12, 12};
    vecs[7]  = '{1'b1, 1, 5, 5, 2, 0};
    vecs[8]  = '{1'b1, 1, 0, 3, 1, 0};
    vecs[9]  = '{1'b1, 1, 7, 6, 2, 0};
    vecs[10] = '{1'b1, 0, 3, 10, 10, 10};

    rstN = 1'b0; start = 1'b0; inttMode = 1'b0; hold = 1'b0; rootSel = 2'd0;
    repeat (2) @(posedge clk);
    #1 checkAllZero("reset");
    rstN = 1'b1;

    applyStimulus(1'b0, 2'd1, -1, -1, -1, 30);
    checkRun("ntt", 0, 2'd1, 30);
    checkTable(1'b0, 30);
    checkOutput("gapHold raddr", trRaddr[10], {4'd6, 4'd2, 4'd0});
    checkOutput("gapHold beat", trBeat[10], 7);

    applyStimulus(1'b1, 2'd2, -1, -1, -1, 30);
    checkRun("intt", 0, 2'd2, 30);
    checkTable(1'b1, 30);

    applyStimulus(1'b0, 2'd3, 3, 5, -1, 30);
    checkRun("hold", 3, 2'd3, 30);
    checkOutput("hold frozen beat", trBeat[5], 2);

    applyStimulus(1'b0, 2'd1, 9, 11, -1, 30);
    checkRun("gapStall", 0, 2'd1, 30);

    applyStimulus(1'b1, 2'd3, -1, -1, -1, 10);
    rstN = 1'b0;
    #1 checkAllZero("midReset");
    @(posedge clk); #1 rstN = 1'b1;
    applyStimulus(1'b0, 2'd2, -1, -1, -1, 30);
    checkRun("afterReset", 0, 2'd2, 30);

    applyStimulus(1'b0, 2'd1, -1, -1, 20, 30);
    checkRun("startInDone", 0, 2'd1, 30);

    applyStimulus(1'b0, 2'd1, -1, -1, 6, 30);
    checkRun("startBusy", 0, 2'd1, 30);
`ifdef TWIDDLE_ERR_FLAG_EN
    checkOutput("err sticky", err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
